fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/if_id_reg.sv | 39 +++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013; // addi x0, x0, 0
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a valid/ready handshake toward decode.
// Priority: flush > capture > drain-on-transfer > hold.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [ILEN-1:0] cap_instr,
  input  logic            flush,
  input  logic            drain,
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] instr
);

  // Valid tracks flush/capture/transfer; payload changes only on capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= ILEN'(INSTR_NOP);
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      pc    <= cap_pc;
      instr <= cap_instr;
    end else if (drain && valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM, redirect/stall/halt
// handling, and the IF/ID output register toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            halted,
  output logic            misaligned
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            capture, flush, drain, set_halt, set_mis;
  logic            advance;

  assign imem_addr = pc;
  // The IF/ID slot can take a new instruction when empty or being drained.
  assign advance   = !out_valid || out_ready;

  // State, PC and sticky status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      halted     <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (set_halt) halted     <= 1'b1;
      if (set_mis)  misaligned <= 1'b1;
    end
  end

  // Next-state and control: redirect beats advance beats hold.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    flush     = 1'b0;
    drain     = 1'b0;
    set_halt  = 1'b0;
    set_mis   = 1'b0;
    unique case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_nxt = redirect_pc;
          end else begin
            // Bad target: keep PC so the faulting context is observable.
            set_mis   = 1'b1;
            state_nxt = HALT;
          end
        end else if (advance) begin
          capture = 1'b1;
          if (imem_instr == ILEN'(INSTR_EBREAK)) begin
            // PC parks on the EBREAK itself.
            set_halt  = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt = pc + XLEN'(4);
          end
        end
      end
      HALT: drain = 1'b1; // let decode take whatever is still held
      default: state_nxt = IDLE;
    endcase
  end

  if_id_reg #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .cap_pc    (pc),
    .cap_instr (imem_instr),
    .flush     (flush),
    .drain     (drain),
    .ready     (out_ready),
    .valid     (out_valid),
    .pc        (out_pc),
    .instr     (out_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic        misaligned;

  logic [31:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted),
    .misaligned     (misaligned)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
  endtask

  task automatic test_reset(input string tag);
    rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_valid got %b exp 0", tag, out_valid); end
    n_cmp++; if (out_pc !== 64'h0) begin n_bad++; $display("FAIL %s_pc got %h exp 0", tag, out_pc); end
    n_cmp++; if (out_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL %s_instr got %h exp 00000013", tag, out_instr); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL %s_halted got %b exp 0", tag, halted); end
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL %s_mis got %b exp 0", tag, misaligned); end
    n_cmp++; if (imem_addr !== 64'h0) begin n_bad++; $display("FAIL %s_addr got %h exp 0", tag, imem_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33; exp_i[3] = 32'h44;
    step(); // IDLE cycle
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_idle_valid got %b exp 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
      n_cmp++; if (out_pc !== 64'(4*i)) begin n_bad++; $display("FAIL stream_pc[%0d] got %h exp %h", i, out_pc, 64'(4*i)); end
      n_cmp++; if (out_instr !== exp_i[i]) begin n_bad++; $display("FAIL stream_instr[%0d] got %h exp %h", i, out_instr, exp_i[i]); end
      n_cmp++; if (imem_addr !== 64'(4*i+4)) begin n_bad++; $display("FAIL stream_addr[%0d] got %h exp %h", i, imem_addr, 64'(4*i+4)); end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h0;
    step(); redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_flush_valid got %b exp 0", out_valid); end
    n_cmp++; if (imem_addr !== 64'h0) begin n_bad++; $display("FAIL stall_flush_addr got %h exp 0", imem_addr); end
    step(); step();
    n_cmp++; if (out_pc !== 64'h4) begin n_bad++; $display("FAIL stall_pre_pc got %h exp 4", out_pc); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b exp 1", i, out_valid); end
      n_cmp++; if (out_pc !== 64'h4) begin n_bad++; $display("FAIL stall_pc[%0d] got %h exp 4", i, out_pc); end
      n_cmp++; if (out_instr !== 32'h22) begin n_bad++; $display("FAIL stall_instr[%0d] got %h exp 22", i, out_instr); end
      n_cmp++; if (imem_addr !== 64'h8) begin n_bad++; $display("FAIL stall_addr[%0d] got %h exp 8", i, imem_addr); end
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_pc !== 64'h8) begin n_bad++; $display("FAIL stall_resume_pc got %h exp 8", out_pc); end
    n_cmp++; if (out_instr !== 32'h33) begin n_bad++; $display("FAIL stall_resume_instr got %h exp 33", out_instr); end
    step();
    n_cmp++; if (out_pc !== 64'hC) begin n_bad++; $display("FAIL stall_next_pc got %h exp c", out_pc); end
    n_cmp++; if (out_instr !== 32'h44) begin n_bad++; $display("FAIL stall_next_instr got %h exp 44", out_instr); end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h100;
    step(); redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid got %b exp 0", out_valid); end
    n_cmp++; if (imem_addr !== 64'h100) begin n_bad++; $display("FAIL redir_addr got %h exp 100", imem_addr); end
    n_cmp++; if (out_pc !== 64'hC) begin n_bad++; $display("FAIL redir_pc_kept got %h exp c", out_pc); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_pc !== 64'h100) begin n_bad++; $display("FAIL redir_cap_pc got %h exp 100", out_pc); end
    n_cmp++; if (out_instr !== 32'hA000_0040) begin n_bad++; $display("FAIL redir_cap_instr got %h exp a0000040", out_instr); end
    n_cmp++; if (imem_addr !== 64'h104) begin n_bad++; $display("FAIL redir_next_addr got %h exp 104", imem_addr); end
    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); redirect_valid = 1'b0;
    n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr got %h exp fffffffffffffffc", imem_addr); end
    step();
    n_cmp++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc got %h exp fffffffffffffffc", out_pc); end
    n_cmp++; if (out_instr !== 32'hA000_00FF) begin n_bad++; $display("FAIL wrap_instr got %h exp a00000ff", out_instr); end
    n_cmp++; if (imem_addr !== 64'h0) begin n_bad++; $display("FAIL wrap_next_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_midrun_reset();
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    step(); redirect_valid = 1'b0;
    n_cmp++; if (imem_addr !== 64'h40) begin n_bad++; $display("FAIL mrst_pre_addr got %h exp 40", imem_addr); end
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    n_cmp++; if (imem_addr !== 64'h0) begin n_bad++; $display("FAIL mrst_addr got %h exp 0", imem_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_pc !== 64'h0) begin n_bad++; $display("FAIL mrst_pc got %h exp 0", out_pc); end
    n_cmp++; if (out_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL mrst_instr got %h exp 00000013", out_instr); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_idle_valid got %b exp 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_restart_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_pc !== 64'h0) begin n_bad++; $display("FAIL mrst_restart_pc got %h exp 0", out_pc); end
    n_cmp++; if (out_instr !== 32'h11) begin n_bad++; $display("FAIL mrst_restart_instr got %h exp 11", out_instr); end
    n_cmp++; if (imem_addr !== 64'h4) begin n_bad++; $display("FAIL mrst_restart_addr got %h exp 4", imem_addr); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 64'h102;
    step();
    n_cmp++; if (misaligned !== 1'b1) begin n_bad++; $display("FAIL mis_flag got %b exp 1", misaligned); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mis_valid got %b exp 0", out_valid); end
    n_cmp++; if (imem_addr !== 64'h4) begin n_bad++; $display("FAIL mis_addr got %h exp 4", imem_addr); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL mis_halted got %b exp 0", halted); end
    redirect_pc = 64'h200;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (imem_addr !== 64'h4) begin n_bad++; $display("FAIL mis_ign_addr[%0d] got %h exp 4", i, imem_addr); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mis_ign_valid[%0d] got %b exp 0", i, out_valid); end
      n_cmp++; if (misaligned !== 1'b1) begin n_bad++; $display("FAIL mis_sticky[%0d] got %b exp 1", i, misaligned); end
      n_cmp++; if (out_pc !== 64'h0) begin n_bad++; $display("FAIL mis_pc[%0d] got %h exp 0", i, out_pc); end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_ebreak();
    mem[2] = 32'h0010_0073;
    step(); step(); step(); step(); // IDLE, cap 0, cap 4, cap 8 (EBREAK)
    n_cmp++; if (out_pc !== 64'h8) begin n_bad++; $display("FAIL ebrk_pc got %h exp 8", out_pc); end
    n_cmp++; if (out_instr !== 32'h0010_0073) begin n_bad++; $display("FAIL ebrk_instr got %h exp 00100073", out_instr); end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL ebrk_halted got %b exp 1", halted); end
    n_cmp++; if (imem_addr !== 64'h8) begin n_bad++; $display("FAIL ebrk_addr got %h exp 8", imem_addr); end
    out_ready = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ebrk_hold_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_pc !== 64'h8) begin n_bad++; $display("FAIL ebrk_hold_pc got %h exp 8", out_pc); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ebrk_drain_valid got %b exp 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ebrk_nocap_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_pc !== 64'h8) begin n_bad++; $display("FAIL ebrk_nocap_pc got %h exp 8", out_pc); end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL ebrk_sticky got %b exp 1", halted); end
    mem[2] = 32'h33;
  endtask

  initial begin
    init_mem();
    test_reset("rst");
    test_stream();
    test_stall();
    test_redirect();
    test_midrun_reset();
    test_misaligned();
    test_reset("rst_after_mis");
    test_ebreak();
    test_reset("rst_after_ebrk");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
